// File: rtl/vortex_banked_sim_mem_pkg.sv
// Shared defaults and types for the banked simulation memory.
// Width defaults come from the VORTEX_AXI_MEM_* / VORTEX_SIM_MEM_* macros; VORTEX_BANKED_SIM_MEM_WRITE_ACK_EN selects write acks.
`ifndef VORTEX_AXI_MEM_DATA_WIDTH
`define VORTEX_AXI_MEM_DATA_WIDTH 512
`endif
`ifndef VORTEX_AXI_MEM_ADDR_WIDTH
`define VORTEX_AXI_MEM_ADDR_WIDTH 32
`endif
`ifndef VORTEX_AXI_MEM_ID_WIDTH
`define VORTEX_AXI_MEM_ID_WIDTH 8
`endif
`ifndef VORTEX_SIM_MEM_WORDS
`define VORTEX_SIM_MEM_WORDS 1024
`endif
`ifndef VORTEX_SIM_MEM_READ_LATENCY
`define VORTEX_SIM_MEM_READ_LATENCY 4
`endif

package vortex_banked_sim_mem_pkg;
  localparam int DEF_DATA_WIDTH   = `VORTEX_AXI_MEM_DATA_WIDTH;
  localparam int DEF_ADDR_WIDTH   = `VORTEX_AXI_MEM_ADDR_WIDTH;
  localparam int DEF_TAG_WIDTH    = `VORTEX_AXI_MEM_ID_WIDTH;
  localparam int DEF_MEM_WORDS    = `VORTEX_SIM_MEM_WORDS;
  localparam int DEF_READ_LATENCY = `VORTEX_SIM_MEM_READ_LATENCY;
  localparam int DEF_FIFO_DEPTH   = 8;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;
endpackage

// File: rtl/vortex_sim_mem_bank.sv
// One memory bank: word array, fixed-latency response pipe, FWFT response FIFO and credit counter.
// VORTEX_BANKED_SIM_MEM_WRITE_ACK_EN makes writes return a zero-data response that consumes a credit.
module vortex_sim_mem_bank
  import vortex_banked_sim_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int MEM_WORDS      = DEF_MEM_WORDS,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int RSP_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_byteen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [BYTES-1:0]      byteen);
    logic [DATA_WIDTH-1:0] merged;
    for (int i = 0; i < BYTES; i++)
      merged[i*8 +: 8] = byteen[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]      idx;
  logic                  fire, rsp_gen, pop, push, credit_ok;
  logic [CNT_W-1:0]      credits, fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;
  logic                  unused_addr;

  // Upper address bits alias and byte-offset bits are ignored.
  assign idx         = req_addr[OFF_W +: IDX_W];
  assign unused_addr = ^req_addr;
  assign credit_ok   = credits < CNT_W'(RSP_FIFO_DEPTH);

`ifdef VORTEX_BANKED_SIM_MEM_WRITE_ACK_EN
  assign req_ready = rst_n & credit_ok;
  assign rsp_gen   = fire;
`else
  assign req_ready = rst_n & ((req_rw == REQ_WRITE) | credit_ok);
  assign rsp_gen   = fire & (req_rw == REQ_READ);
`endif
  assign fire = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (fire && req_rw == REQ_WRITE)
      mem[idx] <= merge_bytes(mem[idx], req_wdata, req_byteen);
  end

  // Stage p0: array sampled combinationally at the accept cycle
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;
  assign vld_p0  = rsp_gen;
  assign data_p0 = (req_rw == REQ_WRITE) ? '0 : mem[idx];
  assign tag_p0  = req_tag;

  // Stages p1..p(L-1): fixed-latency shift pipe; the FIFO write is the final stage
  generate
    if (READ_LATENCY > 1) begin : g_pipe
      localparam int NS = READ_LATENCY - 1;
      logic [NS-1:0]         vld_p;
      logic [DATA_WIDTH-1:0] data_p [NS];
      logic [TAG_WIDTH-1:0]  tag_p  [NS];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= vld_p0;
          for (int k = 1; k < NS; k++) vld_p[k] <= vld_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= data_p0;
        tag_p[0]  <= tag_p0;
        for (int k = 1; k < NS; k++) begin
          data_p[k] <= data_p[k-1];
          tag_p[k]  <= tag_p[k-1];
        end
      end

      assign push      = vld_p[NS-1];
      assign push_data = data_p[NS-1];
      assign push_tag  = tag_p[NS-1];
    end else begin : g_nopipe
      assign push      = vld_p0;
      assign push_data = data_p0;
      assign push_tag  = tag_p0;
    end
  endgenerate

  // FIFO stage: first-word-fall-through; credits cover pipe plus FIFO so it never overflows
  logic [DATA_WIDTH-1:0] fifo_data [RSP_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_FIFO_DEPTH];

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credits  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      credits  <= credits + CNT_W'(rsp_gen) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_tag[wr_ptr]  <= push_tag;
    end
  end
endmodule

// File: rtl/vortex_banked_sim_mem.sv
// Multi-bank simulation memory: NUM_BANKS independent vortex_sim_mem_bank instances behind flattened ports.
// Write acknowledgements are enabled by defining VORTEX_BANKED_SIM_MEM_WRITE_ACK_EN.
module vortex_banked_sim_mem
  import vortex_banked_sim_mem_pkg::*;
#(
  parameter int NUM_BANKS      = 1,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int MEM_WORDS      = DEF_MEM_WORDS,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int RSP_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_BANKS-1:0]              req_valid,
  output logic [NUM_BANKS-1:0]              req_ready,
  input  logic [NUM_BANKS-1:0]              req_rw,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_BANKS*DATA_WIDTH/8-1:0] req_byteen,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_BANKS*TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_BANKS-1:0]              rsp_valid,
  input  logic [NUM_BANKS-1:0]              rsp_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]   rsp_data,
  output logic [NUM_BANKS*TAG_WIDTH-1:0]    rsp_tag
);
  localparam int BYTES = DATA_WIDTH / 8;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vortex_sim_mem_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .TAG_WIDTH     (TAG_WIDTH),
      .MEM_WORDS     (MEM_WORDS),
      .READ_LATENCY  (READ_LATENCY),
      .RSP_FIFO_DEPTH(RSP_FIFO_DEPTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[b]),
      .req_ready (req_ready[b]),
      .req_rw    (req_rw[b]),
      .req_addr  (req_addr[b*ADDR_WIDTH +: ADDR_WIDTH]),
      .req_byteen(req_byteen[b*BYTES +: BYTES]),
      .req_wdata (req_wdata[b*DATA_WIDTH +: DATA_WIDTH]),
      .req_tag   (req_tag[b*TAG_WIDTH +: TAG_WIDTH]),
      .rsp_valid (rsp_valid[b]),
      .rsp_ready (rsp_ready[b]),
      .rsp_data  (rsp_data[b*DATA_WIDTH +: DATA_WIDTH]),
      .rsp_tag   (rsp_tag[b*TAG_WIDTH +: TAG_WIDTH])
    );
  end
endmodule

// File: tb/tb_vortex_banked_sim_mem.sv
// Self-checking bench: per-cycle comparison against a queue-based memory/response model plus directed scenarios.
module tb_vortex_banked_sim_mem;
  localparam int NB = 2, DW = 32, AW = 32, TW = 8, MW = 1024, L = 4, D = 8, BW = DW / 8;
`ifdef VORTEX_BANKED_SIM_MEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NB-1:0]    req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [NB*AW-1:0] req_addr;
  logic [NB*BW-1:0] req_byteen;
  logic [NB*DW-1:0] req_wdata, rsp_data;
  logic [NB*TW-1:0] req_tag, rsp_tag;

  vortex_banked_sim_mem #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .MEM_WORDS(MW), .READ_LATENCY(L), .RSP_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int acc;  // accept cycle
    int due;  // first cycle the response may be visible
    int pc;   // cycle it was handed off
  } ent_t;

  ent_t          mq   [NB][$];
  ent_t          plog [NB][$];
  logic [DW-1:0] mm   [NB][MW];
  logic [NB-1:0] exp_ready, exp_valid;
  int            cyc = 0, n_vec = 0, n_fail = 0;
  bit            checking = 1'b0;
  ent_t          e;
  int            w;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Expected outputs for the current cycle, compared against the DUT
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      exp_ready[b] = rst_n && ((!ACK && req_rw[b]) || mq[b].size() < D);
      exp_valid[b] = (mq[b].size() > 0) && (mq[b][0].due <= cyc);
      if (checking) begin
        chk($sformatf("req_ready[%0d]", b), 64'(req_ready[b]), 64'(exp_ready[b]));
        chk($sformatf("rsp_valid[%0d]", b), 64'(rsp_valid[b]), 64'(exp_valid[b]));
        if (exp_valid[b]) begin
          chk($sformatf("rsp_data[%0d]", b), 64'(rsp_data[b*DW +: DW]), 64'(mq[b][0].d));
          chk($sformatf("rsp_tag[%0d]", b), 64'(rsp_tag[b*TW +: TW]), 64'(mq[b][0].t));
        end
      end
    end
  end

  // Model state update at each edge
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!rst_n) begin
        mq[b].delete();
      end else begin
        if (exp_valid[b] && rsp_ready[b]) begin
          e = mq[b].pop_front();
          e.pc = cyc;
          plog[b].push_back(e);
        end
        if (req_valid[b] && exp_ready[b]) begin
          w = int'(req_addr[b*AW + 2 +: 10]);
          e.t = req_tag[b*TW +: TW];
          e.acc = cyc;
          e.due = cyc + L;
          e.pc = -1;
          if (req_rw[b]) begin
            for (int i = 0; i < BW; i++)
              if (req_byteen[b*BW + i]) mm[b][w][i*8 +: 8] = req_wdata[b*DW + i*8 +: 8];
            e.d = '0;
            if (ACK) mq[b].push_back(e);
          end else begin
            e.d = mm[b][w];
            mq[b].push_back(e);
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(int b, bit rw, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] wd, logic [TW-1:0] t);
    req_valid[b] = 1'b1;
    req_rw[b] = rw;
    req_addr[b*AW +: AW] = a;
    req_byteen[b*BW +: BW] = be;
    req_wdata[b*DW +: DW] = wd;
    req_tag[b*TW +: TW] = t;
  endtask

  task automatic wait_fire(int b);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready[b]) break;
      n++;
      if (n > 200) begin
        fail_timeout($sformatf("accept bank%0d", b));
        break;
      end
    end
    tick(1);
    req_valid[b] = 1'b0;
  endtask

  task automatic req(int b, bit rw, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] wd, logic [TW-1:0] t);
    drive(b, rw, a, be, wd, t);
    wait_fire(b);
  endtask

  function automatic int find_tag(int b, logic [TW-1:0] t);
    int r = -1;
    for (int i = 0; i < plog[b].size(); i++)
      if (plog[b][i].t == t) r = i;
    return r;
  endfunction

  task automatic wait_tag(int b, logic [TW-1:0] t);
    int n = 0;
    while (find_tag(b, t) < 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (find_tag(b, t) < 0) fail_timeout($sformatf("response tag %0d bank%0d", t, b));
    tick(1);
  endtask

  int ix, jx;

  initial begin
    req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0;
    req_wdata = '0; req_tag = '0; rsp_ready = '1;
    tick(3);
    @(negedge clk);
    checking = 1'b1;
    chk("reset req_ready", 64'(req_ready), 64'(0));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_data", 64'(rsp_data), 64'(0));
    chk("reset rsp_tag", 64'(rsp_tag), 64'(0));
    tick(1);
    rst_n = 1'b1;

    // Zero the words used by the rest of the run
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < NB; b++) req(b, 1'b1, AW'(a * 4), '1, '0, '0);
    tick(10);

    // Byte-enable write then read
    plog[0].delete();
    req(0, 1'b1, 32'h40, 4'hF, 32'hAAAAAAAA, 8'd1);
    req(0, 1'b1, 32'h40, 4'h1, 32'h00000055, 8'd2);
    req(0, 1'b0, 32'h40, 4'h0, 32'h0, 8'd3);
    wait_tag(0, 8'd3);
    ix = find_tag(0, 8'd3);
    chk("t1 data", 64'(plog[0][ix].d), 64'h00000000AAAAAA55);
    chk("t1 latency", 64'(plog[0][ix].pc - plog[0][ix].acc), 64'(4));
    tick(8);

    // Back-pressure: 8 credits, 9th waits for the first pop
    plog[0].delete();
    rsp_ready[0] = 1'b0;
    for (int t = 0; t < 8; t++) req(0, 1'b0, AW'(t * 4), '0, '0, TW'(t));
    drive(0, 1'b0, 32'h20, '0, '0, 8'd8);
    repeat (4) begin
      @(negedge clk);
      chk("t2 stalled req_ready", 64'(req_ready[0]), 64'(0));
    end
    tick(1);
    rsp_ready[0] = 1'b1;
    wait_fire(0);
    wait_tag(0, 8'd8);
    for (int t = 0; t < 9; t++) chk($sformatf("t2 order %0d", t), 64'(plog[0][t].t), 64'(t));
    chk("t2 9th accept after first pop", 64'(plog[0][8].acc), 64'(plog[0][0].pc + 1));
    tick(4);

    // Aliasing
    plog[0].delete();
    req(0, 1'b1, 32'(5 * 4), 4'hF, 32'h1234, 8'd10);
    req(0, 1'b0, 32'((5 + 1024) * 4), 4'h0, '0, 8'd11);
    wait_tag(0, 8'd11);
    chk("t3 alias data", 64'(plog[0][find_tag(0, 8'd11)].d), 64'h1234);

    // Read-then-write on consecutive cycles
    plog[0].delete();
    req(0, 1'b0, 32'(3 * 4), 4'h0, '0, 8'd12);
    req(0, 1'b1, 32'(3 * 4), 4'hF, 32'h77, 8'd13);
    req(0, 1'b0, 32'(3 * 4), 4'h0, '0, 8'd14);
    wait_tag(0, 8'd14);
    chk("t4 old data", 64'(plog[0][find_tag(0, 8'd12)].d), 64'h0);
    chk("t4 new data", 64'(plog[0][find_tag(0, 8'd14)].d), 64'h77);

    // Reset with reads in flight
    plog[0].delete();
    for (int t = 20; t < 23; t++) req(0, 1'b0, 32'(5 * 4), '0, '0, TW'(t));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5 req_ready after release", 64'(req_ready[0]), 64'(1));
    repeat (8) begin
      @(negedge clk);
      chk("t5 rsp_valid after reset", 64'(rsp_valid[0]), 64'(0));
      chk("t5 rsp_data after reset", 64'(rsp_data[DW-1:0]), 64'(0));
    end
    tick(1);
    chk("t5 discarded", 64'(find_tag(0, 8'd20)), 64'(-1));
    req(0, 1'b0, 32'(5 * 4), '0, '0, 8'd23);
    wait_tag(0, 8'd23);
    chk("t5 retained", 64'(plog[0][find_tag(0, 8'd23)].d), 64'h1234);

    // Two banks with a different backlog
    req(0, 1'b1, 32'(7 * 4), 4'hF, 32'h00007777, 8'd0);
    req(1, 1'b1, 32'(7 * 4), 4'hF, 32'h11117777, 8'd0);
    tick(8);
    plog[0].delete();
    plog[1].delete();
    rsp_ready[1] = 1'b0;
    req(1, 1'b0, 32'(8 * 4), '0, '0, 8'd30);
    req(1, 1'b0, 32'(9 * 4), '0, '0, 8'd31);
    drive(0, 1'b0, 32'(7 * 4), '0, '0, 8'd40);
    drive(1, 1'b0, 32'(7 * 4), '0, '0, 8'd41);
    tick(1);
    req_valid = '0;
    wait_tag(0, 8'd40);
    ix = find_tag(0, 8'd40);
    chk("t6 bank0 data", 64'(plog[0][ix].d), 64'h00007777);
    chk("t6 bank0 latency", 64'(plog[0][ix].pc - plog[0][ix].acc), 64'(4));
    tick(6);
    rsp_ready[1] = 1'b1;
    wait_tag(1, 8'd41);
    jx = find_tag(1, 8'd41);
    chk("t6 bank1 order", 64'({plog[1][0].t, plog[1][1].t, plog[1][2].t}), 64'({8'd30, 8'd31, 8'd41}));
    chk("t6 bank1 data", 64'(plog[1][jx].d), 64'h11117777);

    // Randomized traffic on both banks
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NB; b++) begin
        req_valid[b] = 1'($urandom_range(0, 1));
        req_rw[b] = 1'($urandom_range(0, 1));
        req_addr[b*AW +: AW] = AW'(($urandom_range(0, 3) * 1024 + $urandom_range(0, 63)) * 4 + $urandom_range(0, 3));
        req_byteen[b*BW +: BW] = BW'($urandom);
        req_wdata[b*DW +: DW] = DW'($urandom);
        req_tag[b*TW +: TW] = TW'($urandom);
        rsp_ready[b] = ($urandom_range(0, 3) != 0);
      end
      tick(1);
    end
    req_valid = '0;
    rsp_ready = '1;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
